// File: rtl/stb_meas_seq.sv
// Strobe measurement sequencer: triggers the generator's period measurement,
// waits for lock, discards settling strobes, then counts strobes and comparator hits.
//
// state   | meaning
// IDLE    | waiting for start_i; results of last run held
// DETECT  | one-cycle period-measure trigger to the generator
// LOCK    | waiting for first strobe rising edge
// SETTLE  | discarding SETTLE_STB strobe edges
// MEASURE | counting strobe edges and comparator hits
// DONE    | one-cycle completion pulse
module stb_meas_seq #(
    parameter int CNT_W      = 16,
    parameter int TO_W       = 32,
    parameter int SETTLE_STB = 2
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_stb_i,
    input  logic [TO_W-1:0]  timeout_i,
    input  logic             stb_i,
    input  logic             gen_err_i,
    input  logic             cmp_i,
    output logic             freq_det_o,
    output logic             oe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] hits_o,
    output logic [CNT_W-1:0] stb_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DETECT, S_LOCK, S_SETTLE, S_MEASURE, S_DONE
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_GEN     = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;
    // Wraps to all-ones when SETTLE_STB is 0; SETTLE is then never entered.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_STB - 1);

    state_t            state_q, state_d;
    logic              stb_prev_q;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  hits_q, hits_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_lim_q, to_lim_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        set_cnt_q, set_cnt_d;
    logic [1:0]        err_q, err_d;
    logic              stb_rise;
    logic              to_exp;
    logic              tmr_active;

    assign stb_rise = stb_i & ~stb_prev_q;
    assign to_exp   = (to_lim_q != '0) && (to_cnt_q == to_lim_q - TO_W'(1));

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= S_IDLE;
            stb_prev_q <= 1'b0;
            n_q        <= '0;
            hits_q     <= '0;
            cnt_q      <= '0;
            to_lim_q   <= '0;
            to_cnt_q   <= '0;
            set_cnt_q  <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            stb_prev_q <= stb_i;
            n_q        <= n_d;
            hits_q     <= hits_d;
            cnt_q      <= cnt_d;
            to_lim_q   <= to_lim_d;
            to_cnt_q   <= to_cnt_d;
            set_cnt_q  <= set_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        hits_d     = hits_q;
        cnt_d      = cnt_q;
        to_lim_d   = to_lim_q;
        set_cnt_d  = set_cnt_q;
        err_d      = err_q;
        tmr_active = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d      = n_stb_i;
                    to_lim_d = timeout_i;
                    hits_d   = '0;
                    cnt_d    = '0;
                    err_d    = '0;
                    state_d  = S_DETECT;
                end
            end
            S_DETECT: begin
                if (abort_i) begin
                    err_d   = ERR_ABORT;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                tmr_active = 1'b1;
                if (abort_i) begin
                    err_d   = ERR_ABORT;
                    state_d = S_DONE;
                end else if (gen_err_i) begin
                    err_d   = ERR_GEN;
                    state_d = S_DONE;
                end else if (stb_rise) begin
                    state_d = (SETTLE_STB == 0) ? S_MEASURE : S_SETTLE;
                end else if (to_exp) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_SETTLE: begin
                tmr_active = 1'b1;
                if (abort_i) begin
                    err_d   = ERR_ABORT;
                    state_d = S_DONE;
                end else if (gen_err_i) begin
                    err_d   = ERR_GEN;
                    state_d = S_DONE;
                end else if (stb_rise) begin
                    if (set_cnt_q == SETTLE_LAST) state_d = S_MEASURE;
                    else set_cnt_d = set_cnt_q + 8'd1;
                end else if (to_exp) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_MEASURE: begin
                tmr_active = 1'b1;
                if (abort_i) begin
                    err_d   = ERR_ABORT;
                    state_d = S_DONE;
                end else if (gen_err_i) begin
                    err_d   = ERR_GEN;
                    state_d = S_DONE;
                end else if (cnt_q == n_q) begin
                    // only reachable with a zero strobe request
                    state_d = S_DONE;
                end else if (stb_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cmp_i) hits_d = hits_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == n_q) state_d = S_DONE;
                end else if (to_exp) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q || stb_rise) to_cnt_d = '0;
        else if (tmr_active) to_cnt_d = to_cnt_q + TO_W'(1);
        else to_cnt_d = to_cnt_q;

        if (state_d != state_q) set_cnt_d = '0;
    end

    assign freq_det_o = (state_q == S_DETECT);
    assign oe_o       = (state_q == S_DETECT) || (state_q == S_LOCK) ||
                        (state_q == S_SETTLE) || (state_q == S_MEASURE);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign err_code_o = err_q;
    assign hits_o     = hits_q;
    assign stb_cnt_o  = cnt_q;

endmodule
